mul_share_ctrl: RTL

- Shares one pipelined 16x16 unsigned multiplier between NREQ game-logic requesters, such as ball physics, paddle motion and score scaling.
- Each cycle, a round-robin arbiter grants at most one request and drives the multiplier operands.
- A tag pipeline of depth LATENCY tracks which requester owns each in-flight product, and the result is returned to that requester with a one-hot valid.
- The block sits between the game FSMs and the multiplier custom-instruction datapath. It drives the multiplier's clk_en.

---
 rtl/mul_share_pkg.sv | 5 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/mul_share_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/mul_share_pkg.sv
// Shared widths for the multiplier-sharing controller.
package mul_share_pkg;
  localparam int unsigned OPW  = 16;
  localparam int unsigned RESW = 32;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin single-grant arbiter: lowest requesting index at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NREQ = 3,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gnt_idx,
  output logic [IDW-1:0]  ptr_next
);

  logic found;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    if (en) begin
      // First pass covers ptr..NREQ-1, second pass the wrapped range 0..ptr-1.
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (IDW'(i) >= ptr)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          gnt_idx  = IDW'(i);
        end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (IDW'(i) < ptr)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          gnt_idx  = IDW'(i);
        end
      end
    end
    ptr_next = ptr;
    if (found) begin
      ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one pipelined 16x16 multiplier between NREQ requesters; a tag pipeline
// routes each product back to its owner with a one-hot valid.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic [NREQ-1:0]      req,
  input  logic [OPW*NREQ-1:0]  req_a,
  input  logic [OPW*NREQ-1:0]  req_b,
  output logic [NREQ-1:0]      grant,
  output logic                 mul_clk_en,
  output logic [OPW-1:0]       mul_dataa,
  output logic [OPW-1:0]       mul_datab,
  input  logic [RESW-1:0]      mul_result,
  output logic [NREQ-1:0]      resp_valid,
  output logic [RESW-1:0]      resp_result,
  output logic                 busy
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW-1:0]     ptr_q, ptr_d, ptr_next, gnt_idx;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [IDW-1:0]     id_q [LATENCY];
  logic [IDW-1:0]     id_d [LATENCY];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .en       (clk_en & rst_n),
    .grant    (grant),
    .gnt_idx  (gnt_idx),
    .ptr_next (ptr_next)
  );

  // Idle operands stay at zero so the multiplier inputs do not toggle.
  always_comb begin
    mul_dataa = '0;
    mul_datab = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        mul_dataa = req_a[i*OPW +: OPW];
        mul_datab = req_b[i*OPW +: OPW];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    vld_d = vld_q;
    id_d  = id_q;
    if (!rst_n) begin
      ptr_d = '0;
      vld_d = '0;
    end else if (clk_en) begin
      ptr_d    = ptr_next;
      vld_d[0] = |grant;
      id_d[0]  = gnt_idx;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
        id_d[k]  = id_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    ptr_q <= ptr_d;
    vld_q <= vld_d;
    id_q  <= id_d;
  end

  always_comb begin
    resp_valid = '0;
    if (vld_q[LATENCY-1] && clk_en && rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (id_q[LATENCY-1] == IDW'(i)) resp_valid[i] = 1'b1;
      end
    end
  end

  assign resp_result = mul_result;
  assign mul_clk_en  = clk_en;
  assign busy        = rst_n & (|vld_q);

endmodule
